regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
Parametrised successor to the single-write, dual-read register bank of the datapath. It provides two asynchronous read ports, one synchronous write port and a per-register busy scoreboard for pending writebacks. An optional hardwired zero register is also provided. It sits between decode, which issues destination registers and reads operands, and writeback, which retires results.

Parameters:
DATA_W, 32, register data width in bits
ADDR_W, 5, register index width; depth NREGS = 2**ADDR_W
ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and is never busy; 0 = register 0 is ordinary

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous active-high reset
regA  input  ADDR_W  read port A index
regB  input  ADDR_W  read port B index
dataA  output  DATA_W  read port A data
dataB  output  DATA_W  read port B data
busyA  output  1  register regA has a pending writeback
busyB  output  1  register regB has a pending writeback
WS  input  1  write enable (writeback strobe)
regW  input  ADDR_W  write index
dataW  input  DATA_W  write data
iss_valid  input  1  issue strobe: mark iss_reg busy
iss_reg  input  ADDR_W  destination register being issued
any_busy  output  1  OR of all busy bits

Behaviour:
- Storage: NREGS x DATA_W array plus NREGS busy bits, all clocked on posedge clk.
- Reset (rst=1 at posedge): all registers cleared to 0; all busy bits cleared.
  - Reset has priority over WS and iss_valid in the same cycle; neither takes effect.
  - Reset asserted mid-stream discards all pending busy state.
  - Post-reset outputs: dataA=dataB=0, busyA=busyB=any_busy=0.
- Write: WS=1 at posedge sets reg[regW] <= dataW.
  - Ignored when ZERO_REG=1 and regW=0.
  - Visible on dataA/dataB in the cycle after the edge (read-after-write latency 1 without bypass).
- Read: dataA/dataB are combinational from regA/regB and the array (full sensitivity, no latch).
  - ZERO_REG=1 and index 0: output forced to 0.
  - regA==regB is legal; both ports return the same value.
- Scoreboard, evaluated at each posedge (rst=0), per register r:
  - iss_valid && iss_reg==r: busy[r] <= 1.
  - else WS && regW==r: busy[r] <= 0.
  - else busy[r] holds.
  - Issue and writeback to the same register in one cycle: busy stays 1, because a new producer is pending.
  - Issue and writeback to different registers in one cycle: both updates apply.
  - Writeback to a non-busy register: data written, busy stays 0 (no error).
  - Re-issue of an already-busy register: busy stays 1. There is no counting; one writeback clears it.
  - ZERO_REG=1: busy[0] is constantly 0 and issue to register 0 is ignored.
- busyA/busyB/any_busy are combinational from the busy bits (plus bypass, see Optional Feature).
- No X propagation: every output is defined after the first reset edge.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - If WS=1 and regW==regA (nonzero when ZERO_REG=1), dataA=dataW and busyA=0 in the same cycle, before the edge. Port B behaves the same against regB.
  - Bypass suppresses busyA/busyB only; it never affects any_busy.
  - If iss_valid also targets the same register, busyX still reads 0 this cycle. The next cycle shows busy=1 per the scoreboard rule.
- Undefined: reads return array contents only; the written value appears one cycle later; busyX reflects stored bits.

Test Plan:
- Reset then read: rst=1 for 1 cycle, regA=3, regB=31 -> dataA=0, dataB=0, busyA=busyB=any_busy=0.
- Write/read: WS=1, regW=1, dataW=0x0000000F; next cycle regA=1 -> dataA=0x0000000F. Bypass build: dataA=0x0000000F already in the write cycle.
- Zero register (ZERO_REG=1): WS=1, regW=0, dataW=0xF000000F, iss_valid=1, iss_reg=0 -> next cycle regA=0 gives dataA=0, busyA=0, any_busy=0.
- Scoreboard: issue reg 5 -> busyA(regA=5)=1, any_busy=1. Next cycle issue reg 5 and WS to reg 5 with 0xAAAA5555 together -> busy stays 1, data=0xAAAA5555. Next WS to reg 5 alone -> busy=0, any_busy=0.
- Mixed: iss_reg=7 with WS to reg 9 (0x12345678) in the same cycle -> busy[7]=1, busy[9]=0, reg9=0x12345678.
- Reset mid-operation: regs 2 and 4 busy, reg2=0xDEADBEEF; rst=1 with WS=1 regW=2 dataW=0x1 -> next cycle reg2=0, all busy=0, any_busy=0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
//------------------------------------------------------------------------------
// Module      : regfile_scoreboard
// Description : Dual-read, single-write register file with a per-register
//               busy scoreboard for pending writebacks. Optional same-cycle
//               write-to-read bypass when REGFILE_BYPASS_EN is defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] regA,
    input  logic [ADDR_W-1:0] regB,
    output logic [DATA_W-1:0] dataA,
    output logic [DATA_W-1:0] dataB,
    output logic              busyA,
    output logic              busyB,
    input  logic              WS,
    input  logic [ADDR_W-1:0] regW,
    input  logic [DATA_W-1:0] dataW,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_reg,
    output logic              any_busy
);

    localparam int   c_NREGS = 2 ** ADDR_W;
    localparam logic c_ZERO  = (ZERO_REG != 0);

    logic [DATA_W-1:0]  r_regs [c_NREGS];
    logic [c_NREGS-1:0] r_busy;
    logic [c_NREGS-1:0] w_busyNext;
    logic               w_wrEn;
    logic               w_zeroA;
    logic               w_zeroB;
    logic               w_bypA;
    logic               w_bypB;

    assign w_wrEn  = WS && !(c_ZERO && (regW == '0));
    assign w_zeroA = c_ZERO && (regA == '0);
    assign w_zeroB = c_ZERO && (regB == '0);

    // Issue is applied after writeback so a same-register pair leaves busy set.
    always_comb begin
        w_busyNext = r_busy;
        if (WS) begin
            w_busyNext[regW] = 1'b0;
        end
        if (iss_valid) begin
            w_busyNext[iss_reg] = 1'b1;
        end
        if (c_ZERO) begin
            w_busyNext[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (w_wrEn) begin
                r_regs[regW] <= dataW;
            end
            r_busy <= w_busyNext;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign w_bypA = w_wrEn && (regW == regA);
    assign w_bypB = w_wrEn && (regW == regB);
`else
    assign w_bypA = 1'b0;
    assign w_bypB = 1'b0;
`endif

    always_comb begin
        dataA = r_regs[regA];
        dataB = r_regs[regB];
        if (w_bypA) begin
            dataA = dataW;
        end
        if (w_bypB) begin
            dataB = dataW;
        end
        if (w_zeroA) begin
            dataA = '0;
        end
        if (w_zeroB) begin
            dataB = '0;
        end
    end

    // Bypass masks the per-port busy view only; any_busy stays on stored bits.
    assign busyA    = r_busy[regA] && !w_bypA;
    assign busyB    = r_busy[regB] && !w_bypB;
    assign any_busy = |r_busy;

endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
// Randomized bench for regfile_scoreboard with a behavioural register/busy model.
`default_nettype none

module tb_regfile_scoreboard;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] regA = '0;
    logic [AW-1:0] regB = '0;
    logic [DW-1:0] dataA;
    logic [DW-1:0] dataB;
    logic          busyA;
    logic          busyB;
    logic          WS = 1'b0;
    logic [AW-1:0] regW = '0;
    logic [DW-1:0] dataW = '0;
    logic          iss_valid = 1'b0;
    logic [AW-1:0] iss_reg = '0;
    logic          any_busy;

    int total = 0;
    int bad   = 0;

    regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst),
        .regA(regA), .regB(regB), .dataA(dataA), .dataB(dataB),
        .busyA(busyA), .busyB(busyB),
        .WS(WS), .regW(regW), .dataW(dataW),
        .iss_valid(iss_valid), .iss_reg(iss_reg), .any_busy(any_busy)
    );

    always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // Reference state: contents and pending-writeback flags per register.
    logic [DW-1:0] mReg [N];
    bit            mBusy [N];
    bit            modelValid = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit bypHit(input logic [AW-1:0] idx);
        return BYP && WS && (regW == idx) && (idx != 0);
    endfunction

    function automatic logic [DW-1:0] expData(input logic [AW-1:0] idx);
        if (idx == 0) return '0;
        if (bypHit(idx)) return dataW;
        return mReg[idx];
    endfunction

    function automatic logic expBusy(input logic [AW-1:0] idx);
        return mBusy[idx] && !bypHit(idx);
    endfunction

    function automatic logic expAny();
        int cnt = 0;
        for (int i = 0; i < N; i++) cnt += int'(mBusy[i]);
        return cnt != 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                mReg[i]  = '0;
                mBusy[i] = 1'b0;
            end
            modelValid = 1'b1;
        end else if (modelValid) begin
            if (WS && regW != 0) mReg[regW] = dataW;
            if (WS) mBusy[regW] = 1'b0;
            if (iss_valid && iss_reg != 0) mBusy[iss_reg] = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (modelValid) begin
            chk("dataA", 64'(dataA), 64'(expData(regA)));
            chk("dataB", 64'(dataB), 64'(expData(regB)));
            chk("busyA", 64'(busyA), 64'(expBusy(regA)));
            chk("busyB", 64'(busyB), 64'(expBusy(regB)));
            chk("any_busy", 64'(any_busy), 64'(expAny()));
        end
    end

    // Drive one cycle of inputs just after the edge, then settle to mid-cycle.
    task automatic cyc(input bit r, input bit ws, input int rw, input logic [DW-1:0] dw,
                       input bit iv, input int ir, input int ra, input int rb);
        @(posedge clk);
        #1;
        rst = r; WS = ws; regW = AW'(rw); dataW = dw;
        iss_valid = iv; iss_reg = AW'(ir); regA = AW'(ra); regB = AW'(rb);
        @(negedge clk);
        #2;
    endtask

    function automatic int pickReg();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, N - 1));
        return int'($urandom_range(0, 7));
    endfunction

    initial begin
        // Reset then read
        cyc(1, 0, 0, 0, 0, 0, 3, 31);
        cyc(0, 0, 0, 0, 0, 0, 3, 31);
        chk("rst_dataA", 64'(dataA), 64'h0);
        chk("rst_dataB", 64'(dataB), 64'h0);
        chk("rst_busy", 64'({busyA, busyB, any_busy}), 64'h0);

        // Write then read
        cyc(0, 1, 1, 32'h0000000F, 0, 0, 1, 0);
        chk("raw_same_cycle", 64'(dataA), BYP ? 64'hF : 64'h0);
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
        chk("raw_next_cycle", 64'(dataA), 64'hF);

        // Zero register ignores write and issue
        cyc(0, 1, 0, 32'hF000000F, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("zero_data", 64'(dataA), 64'h0);
        chk("zero_busy", 64'({busyA, any_busy}), 64'h0);

        // Scoreboard issue / collide / retire
        cyc(0, 0, 0, 0, 1, 5, 5, 0);
        cyc(0, 1, 5, 32'hAAAA5555, 1, 5, 5, 0);
        chk("collide_busyA", 64'(busyA), BYP ? 64'h0 : 64'h1);
        chk("collide_any", 64'(any_busy), 64'h1);
        cyc(0, 0, 0, 0, 0, 0, 5, 5);
        chk("collide_keep_busy", 64'(busyB), 64'h1);
        chk("collide_data", 64'(dataA), 64'hAAAA5555);
        cyc(0, 1, 5, 32'h11, 0, 0, 5, 0);
        cyc(0, 0, 0, 0, 0, 0, 5, 0);
        chk("retire_busy", 64'({busyA, any_busy}), 64'h0);
        chk("retire_data", 64'(dataA), 64'h11);

        // Issue and writeback to different registers
        cyc(0, 1, 9, 32'h12345678, 1, 7, 7, 9);
        cyc(0, 0, 0, 0, 0, 0, 7, 9);
        chk("mixed_busy7", 64'(busyA), 64'h1);
        chk("mixed_busy9", 64'(busyB), 64'h0);
        chk("mixed_data9", 64'(dataB), 64'h12345678);

        // Reset mid-operation discards pending state
        cyc(0, 1, 2, 32'hDEADBEEF, 1, 2, 0, 0);
        cyc(0, 0, 0, 0, 1, 4, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 2, 4);
        chk("pre_rst_busy", 64'({busyA, busyB}), 64'h3);
        chk("pre_rst_data", 64'(dataA), 64'hDEADBEEF);
        cyc(1, 1, 2, 32'h1, 1, 4, 2, 4);
        cyc(0, 0, 0, 0, 0, 0, 2, 4);
        chk("post_rst_data", 64'(dataA), 64'h0);
        chk("post_rst_busy", 64'({busyA, busyB, any_busy}), 64'h0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 1) == 1), pickReg(),
                DW'($urandom()), ($urandom_range(0, 9) < 4), pickReg(), pickReg(), pickReg());
        end

        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
